// File: rtl/aligned_clk_gen_pkg.sv
// Shared types and constants for the edge-aligned divided clock generator.
package aligned_clk_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int DEF_DIV_W = 8;

  // Fixed half-periods of the /2 and /4 lanes, in master clock cycles.
  localparam int HP_D2 = 1;
  localparam int HP_D4 = 2;

endpackage

// File: rtl/aligned_clk_gen_lane.sv
// One divider lane: toggles every hp cycles, restarts high on start, rises only when allowed.
// Outputs registered; is_low reports the value the output takes at the coming edge.
module clk_div_lane #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] hp,
  input  logic         start,
  input  logic         allow_rise,
  output logic         clk_o,
  output logic         ce_o,
  output logic         is_low
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt_q, cnt_nxt;
  logic         clk_q, clk_nxt;
  logic         ce_q, ce_nxt;

  // Counter runs 0..hp-1; hp is never 0 so hp-1 cannot underflow.
  always_comb begin
    clk_nxt = clk_q;
    ce_nxt  = 1'b0;
    cnt_nxt = cnt_q;
    if (start) begin
      clk_nxt = 1'b1;
      ce_nxt  = 1'b1;
      cnt_nxt = '0;
    end else if (cnt_q == hp - ONE) begin
      cnt_nxt = '0;
      if (clk_q) begin
        clk_nxt = 1'b0;
      end else if (allow_rise) begin
        clk_nxt = 1'b1;
        ce_nxt  = 1'b1;
      end
    end else begin
      cnt_nxt = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      clk_q <= 1'b0;
      ce_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_nxt;
      clk_q <= clk_nxt;
      ce_q  <= ce_nxt;
    end
  end

  assign clk_o  = clk_q;
  assign ce_o   = ce_q;
  assign is_low = ~clk_nxt;

endmodule

// File: rtl/aligned_clk_gen.sv
// Edge-aligned /2, /4 and /(2*N) clock outputs plus clock-enable strobes from clk.
// All outputs registered; stopping drains each high phase to its natural fall.
module aligned_clk_gen
  import aligned_clk_gen_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic [DIV_W-1:0] half_per,
  output logic             clk_d2,
  output logic             clk_d4,
  output logic             clk_dn,
  output logic             ce_d2,
  output logic             ce_d4,
  output logic             ce_dn,
  output logic             running
);

  state_t           state_q, state_nxt;
  logic [DIV_W-1:0] hp_q;
  logic             start, allow_rise;
  logic             low_d2, low_d4, low_dn;
  logic             all_low;
  logic             running_q;

  // Lane controls depend only on registered state and inputs, keeping the
  // is_low feedback into next-state free of combinational loops.
  always_comb begin
    start      = 1'b0;
    allow_rise = 1'b0;
    case (state_q)
      IDLE:    start = en;
      RUN: begin
        allow_rise = en;
        start      = en & sync;
      end
      default: ;
    endcase
  end

  assign all_low = low_d2 & low_d4 & low_dn;

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (en) state_nxt = RUN;
      RUN:     if (!en) state_nxt = all_low ? IDLE : DRAIN;
      DRAIN:   if (all_low) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      hp_q      <= DIV_W'(1);
      running_q <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      running_q <= (state_nxt != IDLE);
      if (start) hp_q <= (half_per == '0) ? DIV_W'(1) : half_per;
    end
  end

  assign running = running_q;

  clk_div_lane #(.W(DIV_W)) u_lane_d2 (
    .clk        (clk),
    .rst        (rst),
    .hp         (DIV_W'(HP_D2)),
    .start      (start),
    .allow_rise (allow_rise),
    .clk_o      (clk_d2),
    .ce_o       (ce_d2),
    .is_low     (low_d2)
  );

  clk_div_lane #(.W(DIV_W)) u_lane_d4 (
    .clk        (clk),
    .rst        (rst),
    .hp         (DIV_W'(HP_D4)),
    .start      (start),
    .allow_rise (allow_rise),
    .clk_o      (clk_d4),
    .ce_o       (ce_d4),
    .is_low     (low_d4)
  );

  clk_div_lane #(.W(DIV_W)) u_lane_dn (
    .clk        (clk),
    .rst        (rst),
    .hp         (hp_q),
    .start      (start),
    .allow_rise (allow_rise),
    .clk_o      (clk_dn),
    .ce_o       (ce_dn),
    .is_low     (low_dn)
  );

endmodule

// File: doc/aligned_clk_gen.md
Name: aligned_clk_gen

Overview:
- Synthesizable generator of edge-aligned divided clock signals and matching clock-enable strobes, all from the single master clock `clk`.
- Produces /2, /4 and programmable /(2*N) outputs whose rising edges all coincide at start and after every resync.
- Sits directly downstream of the master clock source; it feeds multi-rate datapath logic, which should use the ce_* strobes rather than clocking on the divided outputs.

Parameters:
- DIV_W, 8: width of the programmable half-period input and its internal counter.

Ports:
- clk  input  1  master clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset; priority over every other input.
- en  input  1  run request; level-sensitive.
- sync  input  1  single-cycle realign request; honoured only while running.
- half_per  input  DIV_W  half-period of clk_dn, in clk cycles; sampled only at start and at sync; value 0 is treated as 1.
- clk_d2  output  1  clk divided by 2.
- clk_d4  output  1  clk divided by 4.
- clk_dn  output  1  clk divided by 2*half_per.
- ce_d2  output  1  one-cycle pulse in each cycle where clk_d2 is newly high.
- ce_d4  output  1  one-cycle pulse in each cycle where clk_d4 is newly high.
- ce_dn  output  1  one-cycle pulse in each cycle where clk_dn is newly high.
- running  output  1  high whenever state is not IDLE.

Behaviour:
- Conventions: all outputs are registered. "Cycle n" means the period after clock edge n. Inputs sampled at edge n affect cycle n.
- Reset (rst=1 at an edge):
  - state=IDLE; all clk_*, ce_* and running become 0.
  - Latched half-period hp_q=1; all lane counters cleared.
  - Applies mid-run too, with no drain.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - Outputs are held at 0.
  - en=1 -> RUN. In that same edge: hp_q=max(half_per,1); all three clk_* become 1; all three ce_* pulse; lane counters load phase 0.
- RUN:
  - clk_d2 toggles every cycle.
  - clk_d4 toggles every 2 cycles.
  - clk_dn toggles every hp_q cycles.
  - ce_x is 1 exactly in cycles where clk_x went 0->1.
- sync=1 in RUN (with en=1):
  - Identical to start: re-latch hp_q, force all outputs to 1, pulse all ce_*, reset counters.
  - Applies even if an output was already high.
- sync in IDLE or DRAIN: ignored.
- en=0 in RUN -> DRAIN, taking effect at that edge:
  - No output may rise and no ce_* may pulse.
  - Each output that is high continues until its scheduled fall, then holds 0.
  - Outputs already low stay low.
- DRAIN exit: at the edge where all three outputs become or are 0, state -> IDLE and running=0 in that cycle.
- en re-asserted during DRAIN is ignored until IDLE is reached; a start then happens at the next edge where en=1.
- No output glitches. Every high and low phase is a whole number of clk cycles, with full length except when truncated by rst or sync.
- Counter arithmetic: lane counters count 0..hp-1 and wrap to 0 on toggle. hp_q=2^DIV_W-1 must work with no overflow.

Decomposition:
- Package aligned_clk_gen_pkg holds:
  - state typedef enum {IDLE, RUN, DRAIN};
  - default DIV_W;
  - localparams HP_D2=1 and HP_D4=2.
- Sub-module clk_div_lane (one per output, instantiated 3 times), with inputs:
  - half-period;
  - start/realign strobe;
  - allow_rise;
- and outputs clk_o, ce_o and is_low.

Test Plan:
- Basic run:
  - Stimulus: rst, then en=1 from edge 0, half_per=3.
  - clk_d2 in cycles 0-7: 10101010.
  - clk_d4 in cycles 0-7: 11001100.
  - clk_dn in cycles 0-11: 111000111000.
  - ce_d4 pulses at 0,4,8; ce_dn pulses at 0,6,12; running=1 throughout.
- Resync:
  - Stimulus: same setup, sync=1 at edge 5 with half_per=2.
  - Cycle 5: all clk_*=1 and all ce_*=1.
  - clk_dn after that: 1100 repeating; next ce_dn at 9.
- Drain:
  - Stimulus: half_per=3, en=0 at edge 2.
  - clk_d2 stays 0 from cycle 2; clk_d4 is 0 from cycle 2; clk_dn stays 1 in cycle 2 and falls in cycle 3.
  - State is IDLE in cycle 3 with running=0; no ce_* pulses in cycles 2-3.
- Degenerate divide:
  - Stimulus: half_per=0, en=1.
  - clk_dn is identical to clk_d2, and ce_dn is identical to ce_d2.
- Reset mid-run:
  - Stimulus: rst=1 at edge 7 during RUN, with en still 1.
  - Cycle 7: all outputs 0.
  - After rst drops at edge 8, a restart occurs in cycle 8 with all outputs 1.
- Max divide:
  - Stimulus: half_per=255.
  - clk_dn is high for exactly 255 cycles, then low for 255; ce_dn pulses at 0 and 510.
